// File: rtl/vga_bus_writer_pkg.sv
// Shared constants, register map and types for the VGA framebuffer bus writer.
package vga_bus_writer_pkg;

  localparam int unsigned H_RES      = 256;
  localparam int unsigned V_RES      = 192;
  localparam int unsigned FB_DEPTH   = H_RES * V_RES / 8;
  localparam int unsigned ADDR_BITS  = $clog2(FB_DEPTH);
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned ENTRY_BITS = ADDR_BITS + DATA_BITS;

  localparam logic [1:0] REG_ADDR_LO = 2'd0;
  localparam logic [1:0] REG_ADDR_HI = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int unsigned CTRL_CLEAR   = 0;
  localparam int unsigned CTRL_CLR_OVF = 1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CLEAR_WAIT = 2'd1,
    ST_CLEAR      = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
  } fb_entry_t;

  // Wraps at the last framebuffer byte; out-of-range addresses count on modulo 2^ADDR_BITS.
  function automatic logic [ADDR_BITS-1:0] fb_addr_inc(input logic [ADDR_BITS-1:0] a);
    if (a == ADDR_BITS'(FB_DEPTH - 1)) return '0;
    return a + ADDR_BITS'(1);
  endfunction

endpackage

// File: rtl/vga_bus_writer_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop frees a slot in the same cycle.
module vga_bus_writer_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata_c,
  output logic             o_full_c,
  output logic             o_empty_c
);

  localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [PTR_BITS-1:0] r_wr_ptr;
  logic [PTR_BITS-1:0] r_rd_ptr;
  logic [PTR_BITS:0]   r_count;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_full_c  = (r_count == (PTR_BITS+1)'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_rdata_c = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty_c;
  assign w_do_push = i_push & (~o_full_c | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_BITS+1)'(1);
        2'b01:   r_count <= r_count - (PTR_BITS+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vga_bus_writer.sv
// Host-bus writer for the mono framebuffer: decodes I/O writes, buffers pixel bytes and
// drains them (or a hardware clear-screen fill) only while the display is blanking.
module vga_bus_writer
  import vga_bus_writer_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_iorq,
  input  logic                 i_write,
  input  logic [1:0]           i_chipsel,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_visible,
  output logic                 o_fb_we,
  output logic [ADDR_BITS-1:0] o_fb_addr,
  output logic [DATA_BITS-1:0] o_fb_wdata,
  output logic                 o_busy,
  output logic                 o_overflow
);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_sync3;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_fill;
  logic [ADDR_BITS-1:0] r_clr_cnt;
  state_t               r_state;

  logic                 w_edge;
  logic                 w_push_req;
  logic                 w_clr_req;
  logic                 w_ovf_clr;
  logic                 w_drop;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  fb_entry_t            w_push_entry;
  fb_entry_t            w_head;
  state_t               w_state_nxt;
  logic [ADDR_BITS-1:0] w_clr_cnt_nxt;
  logic                 w_fb_we_nxt;
  logic [ADDR_BITS-1:0] w_fb_addr_nxt;
  logic [DATA_BITS-1:0] w_fb_wdata_nxt;

  // Strobe is asynchronous to clk: two-flop synchronizer plus a delayed copy for edge detect.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_iorq & i_write;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_edge       = r_sync2 & ~r_sync3;
  assign w_push_req   = w_edge & (i_chipsel == REG_DATA) & (r_addr < ADDR_BITS'(FB_DEPTH));
  assign w_clr_req    = w_edge & (i_chipsel == REG_CTRL) & i_data[CTRL_CLEAR];
  assign w_ovf_clr    = w_edge & (i_chipsel == REG_CTRL) & i_data[CTRL_CLR_OVF];
  assign w_drop       = w_push_req & w_full & ~w_pop;
  assign w_push_entry = '{addr: r_addr, data: i_data};

  vga_bus_writer_sync_fifo #(
    .WIDTH (ENTRY_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_reset),
    .i_push    (w_push_req),
    .i_pop     (w_pop),
    .i_wdata   (w_push_entry),
    .o_rdata_c (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_addr <= '0;
    end else if (w_edge) begin
      case (i_chipsel)
        REG_ADDR_LO: r_addr[7:0]           <= i_data;
        REG_ADDR_HI: r_addr[ADDR_BITS-1:8] <= i_data[ADDR_BITS-9:0];
        REG_DATA:    r_addr                <= fb_addr_inc(r_addr);
        default:     r_addr                <= r_addr;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
      r_fill    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      if (w_clr_req) r_fill <= {DATA_BITS{i_data[DATA_BITS-1]}};
    end
  end

  // Drain FIFO while blanking; CLEAR_WAIT empties it before the fill so queued bytes are not lost.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_cnt_nxt  = r_clr_cnt;
    w_pop          = 1'b0;
    w_fb_we_nxt    = 1'b0;
    w_fb_addr_nxt  = o_fb_addr;
    w_fb_wdata_nxt = o_fb_wdata;
    case (r_state)
      ST_IDLE, ST_CLEAR_WAIT: begin
        if (!i_visible && !w_empty) begin
          w_pop          = 1'b1;
          w_fb_we_nxt    = 1'b1;
          w_fb_addr_nxt  = w_head.addr;
          w_fb_wdata_nxt = w_head.data;
        end
        if ((r_state == ST_CLEAR_WAIT) && w_empty) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end
      ST_CLEAR: begin
        if (!i_visible) begin
          w_fb_we_nxt    = 1'b1;
          w_fb_addr_nxt  = r_clr_cnt;
          w_fb_wdata_nxt = r_fill;
          if (r_clr_cnt == ADDR_BITS'(FB_DEPTH - 1)) w_state_nxt = ST_IDLE;
          else                                         w_clr_cnt_nxt = r_clr_cnt + ADDR_BITS'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_clr_req) begin
      w_state_nxt   = (r_state == ST_CLEAR) ? ST_CLEAR : ST_CLEAR_WAIT;
      w_clr_cnt_nxt = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_fb_we    <= 1'b0;
      o_fb_addr  <= '0;
      o_fb_wdata <= '0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_fb_we    <= w_fb_we_nxt;
      o_fb_addr  <= w_fb_addr_nxt;
      o_fb_wdata <= w_fb_wdata_nxt;
      o_busy     <= ~w_empty | (r_state != ST_IDLE);
      if (w_ovf_clr)   o_overflow <= 1'b0;
      else if (w_drop) o_overflow <= 1'b1;
    end
  end

endmodule
